// File: rtl/flash_pkg.sv
// Shared types and constants for the configuration-flash SPI transaction sequencer.
package flash_pkg;

   localparam int LEN_W = 9;

   localparam logic [7:0] OP_WREN = 8'h06;
   localparam logic [7:0] OP_READ = 8'h03;
   localparam logic [7:0] OP_PP   = 8'h02;
   localparam logic [7:0] OP_RDSR = 8'h05;
   localparam logic [7:0] OP_SE   = 8'hD8;

   typedef enum logic [2:0] {
      S_IDLE, S_SETUP, S_CMD, S_A2, S_A1, S_A0, S_DATA, S_HIGH
   } state_t;

   // States that occupy a shifter byte slot
   function automatic logic is_byte_state(input state_t s);
      return s inside {[S_CMD:S_DATA]};
   endfunction

endpackage

// File: rtl/flash_slot_timer.sv
// Byte-slot counter: runs while a byte state is active, flags the write strobe
// cycle (0) and the read-strobe / last cycle of each slot.
module flash_slot_timer #(
   parameter int BYTE_CYCLES = 18
) (
   input  logic CLK,
   input  logic RST,
   input  logic run,
   output logic slot_start,
   output logic slot_cap,
   output logic slot_end
);

   logic [4:0] cnt;

   // Held at zero outside byte states so the first slot always starts at cycle 0
   always_ff @(posedge CLK or posedge RST) begin
      if (RST)                                cnt <= '0;
      else if (!run)                          cnt <= '0;
      else if (cnt == 5'(BYTE_CYCLES - 1))    cnt <= '0;
      else                                    cnt <= cnt + 5'd1;
   end

   assign slot_start = run && (cnt == 5'd0);
   assign slot_cap   = run && (cnt == 5'(BYTE_CYCLES - 1));
   assign slot_end   = run && (cnt == 5'(BYTE_CYCLES - 1));

endmodule

// File: rtl/flash_seq.sv
// Flash transaction sequencer: chip select, opcode, optional 24-bit address,
// LEN data bytes in either direction, then enforced chip-select-high time.
module flash_seq
   import flash_pkg::*;
#(
   parameter int BYTE_CYCLES = 18,
   parameter int CS_SETUP    = 2,
   parameter int CS_HIGH     = 4
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   input  logic             RNW,
   input  logic             HASADDR,
   input  logic [7:0]       CMD,
   input  logic [23:0]      ADDR,
   input  logic [LEN_W-1:0] LEN,
   input  logic [7:0]       WDATA,
   output logic             WACK,
   output logic [7:0]       RDATA,
   output logic             RSTB,
   output logic             BUSY,
   output logic             FCS,
   output logic             BWS,
   output logic [7:0]       BDO,
   output logic             BRS,
   input  logic [7:0]       BDI
);

   state_t           state;
   logic [7:0]       cmd_q;
   logic [23:0]      addr_q;
   logic             rnw_q;
   logic             hasaddr_q;
   logic [LEN_W-1:0] rem;
   logic [7:0]       wcnt;
   logic             slot_start, slot_cap, slot_end;
   logic [7:0]       obyte;

   flash_slot_timer #(.BYTE_CYCLES(BYTE_CYCLES)) u_timer (
      .CLK        (CLK),
      .RST        (RST),
      .run        (is_byte_state(state)),
      .slot_start (slot_start),
      .slot_cap   (slot_cap),
      .slot_end   (slot_end)
   );

   always_comb begin
      obyte = 8'h00;
      case (state)
         S_CMD:   obyte = cmd_q;
         S_A2:    obyte = addr_q[23:16];
         S_A1:    obyte = addr_q[15:8];
         S_A0:    obyte = addr_q[7:0];
         S_DATA:  obyte = rnw_q ? 8'h00 : WDATA;
         default: obyte = 8'h00;
      endcase
   end

   // Write data is taken straight from WDATA in the strobe cycle, so BDO is a mux, not a register
   assign BWS  = slot_start;
   assign BRS  = slot_cap;
   assign BDO  = slot_start ? obyte : 8'h00;
   assign WACK = slot_start && (state == S_DATA) && !rnw_q;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state     <= S_IDLE;
         FCS       <= 1'b1;
         BUSY      <= 1'b0;
         RDATA     <= 8'h00;
         RSTB      <= 1'b0;
         cmd_q     <= 8'h00;
         addr_q    <= 24'h0;
         rnw_q     <= 1'b0;
         hasaddr_q <= 1'b0;
         rem       <= '0;
         wcnt      <= 8'h00;
      end else begin
         RSTB <= 1'b0;
         if (state == S_DATA && rnw_q && slot_cap) begin
            RDATA <= BDI;
            RSTB  <= 1'b1;
         end
         case (state)
            S_IDLE: if (START) begin
               cmd_q     <= CMD;
               addr_q    <= ADDR;
               rnw_q     <= RNW;
               hasaddr_q <= HASADDR;
               rem       <= LEN;
               wcnt      <= 8'h00;
               FCS       <= 1'b0;
               BUSY      <= 1'b1;
               state     <= S_SETUP;
            end
            S_SETUP: begin
               if (wcnt == 8'(CS_SETUP - 1)) begin
                  wcnt  <= 8'h00;
                  state <= S_CMD;
               end else begin
                  wcnt <= wcnt + 8'd1;
               end
            end
            S_CMD: if (slot_end) begin
               if (hasaddr_q)       state <= S_A2;
               else if (rem != '0)  state <= S_DATA;
               else begin
                  state <= S_HIGH;
                  FCS   <= 1'b1;
               end
            end
            S_A2: if (slot_end) state <= S_A1;
            S_A1: if (slot_end) state <= S_A0;
            S_A0: if (slot_end) begin
               if (rem != '0) state <= S_DATA;
               else begin
                  state <= S_HIGH;
                  FCS   <= 1'b1;
               end
            end
            // rem is 9 bits so LEN=256 runs 256 slots down to zero without wrapping
            S_DATA: if (slot_end) begin
               rem <= rem - 1'b1;
               if (rem == LEN_W'(1)) begin
                  state <= S_HIGH;
                  FCS   <= 1'b1;
               end
            end
            S_HIGH: begin
               if (wcnt == 8'(CS_HIGH - 1)) begin
                  wcnt  <= 8'h00;
                  BUSY  <= 1'b0;
                  state <= S_IDLE;
               end else begin
                  wcnt <= wcnt + 8'd1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_flash_seq.sv
// Directed bench for flash_seq: a negedge monitor tallies strobes and chip-select
// timing per transaction and plays the shifter's returned bytes.
module tb_flash_seq;
   import flash_pkg::*;

   logic        CLK, RST, START, RNW, HASADDR;
   logic [7:0]  CMD, WDATA, BDI;
   logic [23:0] ADDR;
   logic [8:0]  LEN;
   logic        WACK, RSTB, BUSY, FCS, BWS, BRS;
   logic [7:0]  RDATA, BDO;

   flash_seq dut (
      .CLK(CLK), .RST(RST), .START(START), .RNW(RNW), .HASADDR(HASADDR),
      .CMD(CMD), .ADDR(ADDR), .LEN(LEN), .WDATA(WDATA), .WACK(WACK),
      .RDATA(RDATA), .RSTB(RSTB), .BUSY(BUSY), .FCS(FCS), .BWS(BWS),
      .BDO(BDO), .BRS(BRS), .BDI(BDI)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int vecs = 0;
   int errs = 0;

   int cyc = 0, st_cyc = 0, first_bws = 0, last_bws = 0;
   int fcs_lo = 0, busy_hi = 0, bws_n = 0, rstb_n = 0, wack_n = 0;
   int wack_bad = 0, gap_bad = 0, brs_n = 0;
   logic [7:0] bdo_log [0:299];
   logic [7:0] rd_log  [0:299];
   logic [7:0] rtab    [0:7];
   logic [7:0] wtab    [0:3];
   int widx = 0;
   logic [7:0] idx8;

   initial BDI = 8'h00;

   always @(negedge CLK) begin
      cyc++;
      if (START && !BUSY) begin
         st_cyc = cyc; fcs_lo = 0; busy_hi = 0; bws_n = 0; rstb_n = 0;
         wack_n = 0; wack_bad = 0; gap_bad = 0; brs_n = 0;
      end else begin
         if (!FCS) fcs_lo++;
         if (BUSY) busy_hi++;
         if (BWS) begin
            if (bws_n < 300) bdo_log[bws_n] = BDO;
            if (bws_n == 0) first_bws = cyc;
            else if (cyc - last_bws != 18) gap_bad++;
            last_bws = cyc;
            bws_n++;
         end
         if (RSTB) begin
            if (rstb_n < 300) rd_log[rstb_n] = RDATA;
            rstb_n++;
         end
         if (WACK) begin
            wack_n++;
            if (!BWS) wack_bad++;
         end
         if (BRS) begin
            idx8 = brs_n[7:0];
            BDI  = (brs_n < 8) ? rtab[brs_n] : idx8;
            brs_n++;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic start_txn(input logic [7:0] c, input logic [23:0] a, input logic r,
                            input logic h, input logic [8:0] l);
      CMD = c; ADDR = a; RNW = r; HASADDR = h; LEN = l;
      START = 1'b1;
      @(posedge CLK); #1;
      START = 1'b0;
   endtask

   task automatic run_to_idle(input int lim);
      int n = 0;
      logic wseen = 1'b0;
      while (BUSY && n < lim) begin
         @(posedge CLK); #1;
         n++;
         if (wseen && widx < 3) begin
            widx++;
            WDATA = wtab[widx];
         end
         wseen = WACK;
      end
      chk("idle_timeout", {31'd0, BUSY}, 32'd0);
   endtask

   initial begin
      int nb;
      RST = 1'b1; START = 1'b0; RNW = 1'b0; HASADDR = 1'b0;
      CMD = 8'h00; ADDR = 24'h0; LEN = 9'd0; WDATA = 8'h00;
      for (int i = 0; i < 8; i++) rtab[i] = 8'h00;
      rtab[1] = 8'h7E; rtab[4] = 8'hA5; rtab[5] = 8'h5A;
      wtab[0] = 8'h11; wtab[1] = 8'h22; wtab[2] = 8'h33; wtab[3] = 8'h00;

      repeat (3) @(posedge CLK);
      #1;
      chk("rst_fcs", FCS, 1); chk("rst_busy", BUSY, 0); chk("rst_bws", BWS, 0);
      chk("rst_brs", BRS, 0); chk("rst_wack", WACK, 0); chk("rst_rstb", RSTB, 0);
      chk("rst_bdo", BDO, 0); chk("rst_rdata", RDATA, 0);
      RST = 1'b0;
      @(posedge CLK); #1;

      // WREN, no address, no data
      start_txn(OP_WREN, 24'h0, 1'b0, 1'b0, 9'd0);
      run_to_idle(100);
      chk("wren_bws_n", bws_n, 1); chk("wren_bdo", bdo_log[0], 8'h06);
      chk("wren_fcs_lo", fcs_lo, 20); chk("wren_busy", busy_hi, 24);
      chk("wren_rstb_n", rstb_n, 0); chk("wren_wack_n", wack_n, 0);
      chk("wren_first_bws", first_bws - st_cyc, 3);

      // READ 0x123456, 2 bytes; started in the first IDLE cycle
      start_txn(OP_READ, 24'h123456, 1'b1, 1'b1, 9'd2);
      run_to_idle(200);
      chk("rd_bws_n", bws_n, 6);
      chk("rd_bdo0", bdo_log[0], 8'h03); chk("rd_bdo1", bdo_log[1], 8'h12);
      chk("rd_bdo2", bdo_log[2], 8'h34); chk("rd_bdo3", bdo_log[3], 8'h56);
      chk("rd_bdo4", bdo_log[4], 8'h00); chk("rd_bdo5", bdo_log[5], 8'h00);
      chk("rd_rstb_n", rstb_n, 2);
      chk("rd_data0", rd_log[0], 8'hA5); chk("rd_data1", rd_log[1], 8'h5A);
      chk("rd_fcs_lo", fcs_lo, 110); chk("rd_busy", busy_hi, 114);
      chk("rd_gap", gap_bad, 0);

      // Page program, 3 bytes
      widx = 0; WDATA = wtab[0];
      @(posedge CLK); #1;
      start_txn(OP_PP, 24'h000000, 1'b0, 1'b1, 9'd3);
      run_to_idle(250);
      chk("pp_bws_n", bws_n, 7); chk("pp_wack_n", wack_n, 3);
      chk("pp_wack_bws", wack_bad, 0); chk("pp_rstb_n", rstb_n, 0);
      chk("pp_bdo0", bdo_log[0], 8'h02); chk("pp_bdo4", bdo_log[4], 8'h11);
      chk("pp_bdo5", bdo_log[5], 8'h22); chk("pp_bdo6", bdo_log[6], 8'h33);
      chk("pp_fcs_lo", fcs_lo, 128);

      // 256-byte read, counter must not wrap
      start_txn(OP_READ, 24'h00ABCD, 1'b1, 1'b1, 9'd256);
      run_to_idle(6000);
      chk("l256_rstb_n", rstb_n, 256); chk("l256_bws_n", bws_n, 260);
      chk("l256_fcs_lo", fcs_lo, 2 + 260 * 18); chk("l256_busy", busy_hi, 2 + 260 * 18 + 4);
      chk("l256_last", rd_log[255], 8'h03); chk("l256_gap", gap_bad, 0);

      // START pulsed during the A1 slot is ignored
      start_txn(OP_READ, 24'hABCDEF, 1'b1, 1'b1, 9'd1);
      nb = 0;
      for (int i = 0; i < 200 && nb < 3; i++) begin
         @(posedge CLK); #1;
         if (BWS) nb++;
      end
      chk("a1_reached", nb, 3);
      repeat (5) begin @(posedge CLK); #1; end
      CMD = OP_SE; LEN = 9'd0; HASADDR = 1'b0; RNW = 1'b0;
      START = 1'b1;
      @(posedge CLK); #1;
      START = 1'b0;
      run_to_idle(300);
      chk("ign_bws_n", bws_n, 5);
      chk("ign_bdo0", bdo_log[0], 8'h03); chk("ign_bdo1", bdo_log[1], 8'hAB);
      chk("ign_bdo2", bdo_log[2], 8'hCD); chk("ign_bdo3", bdo_log[3], 8'hEF);
      chk("ign_rstb_n", rstb_n, 1);
      chk("ign_fcs_lo", fcs_lo, 92); chk("ign_busy", busy_hi, 96);

      // Reset at slot cycle 9 of the second data byte
      start_txn(OP_READ, 24'h000100, 1'b1, 1'b1, 9'd4);
      nb = 0;
      for (int i = 0; i < 300 && nb < 6; i++) begin
         @(posedge CLK); #1;
         if (BWS) nb++;
      end
      chk("d1_reached", nb, 6);
      repeat (9) begin @(posedge CLK); #1; end
      RST = 1'b1;
      #1;
      chk("arst_fcs", FCS, 1); chk("arst_busy", BUSY, 0); chk("arst_bws", BWS, 0);
      @(posedge CLK); #1;
      RST = 1'b0;
      @(posedge CLK); #1;
      chk("post_rst_fcs", FCS, 1); chk("post_rst_busy", BUSY, 0);
      start_txn(OP_RDSR, 24'h0, 1'b1, 1'b0, 9'd1);
      run_to_idle(100);
      chk("rdsr_bws_n", bws_n, 2); chk("rdsr_bdo0", bdo_log[0], 8'h05);
      chk("rdsr_rstb_n", rstb_n, 1); chk("rdsr_data", rd_log[0], 8'h7E);
      chk("rdsr_fcs_lo", fcs_lo, 38); chk("rdsr_busy", busy_hi, 42);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
